// File: rtl/dm_bus_responder_pkg.sv
// Shared types and helpers for the data-memory bus responder.
// Holds the FSM encoding, default depth and the byte-lane merge.
package dm_bus_responder_pkg;

   localparam int DM_DEPTH_WORDS = 3072;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dm_state_e;

   // Replace each enabled byte lane of old_w with the matching lane of wdata.
   function automatic logic [31:0] merge(
      input logic [31:0] old_w,
      input logic [31:0] wdata,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dm_word_array.sv
// DEPTH x 32-bit word storage: synchronous clear, byte-enabled write,
// combinational read. Ports: clk, reset, we/waddr/be/wdata, raddr/rdata.
module dm_word_array
   import dm_bus_responder_pkg::*;
#(
   parameter int DEPTH = DM_DEPTH_WORDS,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[waddr] <= merge(mem_q[waddr], wdata, be);
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/dm_bus_responder.sv
// MEM-stage data-memory responder: valid/ready request, LATENCY wait
// states, one-cycle response, byte-enabled stores and a store trace.
// Ports: req_* (request), resp_* (response), trc_* (store trace).
module dm_bus_responder
   import dm_bus_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
   parameter int LATENCY     = 0,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [3:0]        req_be,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              trc_valid,
   output logic [31:0]       trc_pc,
   output logic [31:0]       trc_addr,
   output logic [31:0]       trc_data
);

   localparam int IW = ADDR_W - 2;
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] LAT_M1 =
      (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
   localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH_WORDS);

   dm_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic        ok_q, ok_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] word_q, word_d;

   logic          accept, req_ok, rd_ok, commit;
   logic [IW-1:0] req_idx, rd_idx;
   logic [31:0]   arr_rdata, fwd_word;
   logic          unused_bits;

   assign unused_bits = ^req_addr[1:0];
   assign req_idx = req_addr[ADDR_W-1:2];
   assign req_ok  = {1'b0, req_idx} < DEPTH_L;

   assign req_ready = (state_q != ST_WAIT);
   assign accept    = req_valid && req_ready;
   assign commit    = (state_q == ST_RESP) && we_q && ok_q
                      && (be_q != 4'b0000);

   // Word latched on the edge entering RESP: the incoming request when
   // it goes straight to RESP, otherwise the one waiting in WAIT.
   assign rd_idx = accept ? req_idx : idx_q;
   assign rd_ok  = accept ? req_ok : ok_q;

   // A store committing on this same edge must be visible to the latch.
   assign fwd_word = (commit && rd_idx == idx_q)
                     ? merge(arr_rdata, wdata_q, be_q) : arr_rdata;

   dm_word_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
      .clk   (clk),
      .reset (reset),
      .we    (commit),
      .waddr (idx_q[AW-1:0]),
      .be    (be_q),
      .wdata (wdata_q),
      .raddr (rd_idx[AW-1:0]),
      .rdata (arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      ok_d    = ok_q;
      idx_d   = idx_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      pc_d    = pc_q;
      word_d  = word_q;
      unique case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         we_d    = req_we;
         ok_d    = req_ok;
         idx_d   = req_idx;
         be_d    = req_be;
         wdata_d = req_wdata;
         pc_d    = req_pc;
      end
      if (state_d == ST_RESP) word_d = rd_ok ? fwd_word : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         ok_q    <= 1'b0;
         idx_q   <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         ok_q    <= ok_d;
         idx_q   <= idx_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         pc_q    <= pc_d;
         word_q  <= word_d;
      end
   end

   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = resp_valid && !ok_q;
   assign resp_rdata = (resp_valid && ok_q && !we_q) ? word_q : '0;
   assign trc_valid  = commit;
   assign trc_pc     = commit ? pc_q : '0;
   assign trc_addr   = commit ? 32'({idx_q, 2'b00}) : '0;
   assign trc_data   = commit ? merge(word_q, wdata_q, be_q) : '0;

endmodule

// File: tb/tb_dm_bus_responder.sv
// Bench for dm_bus_responder: LATENCY=0 and LATENCY=3 instances,
// directed cases plus random traffic against a word-array model.
module tb_dm_bus_responder;

   localparam int DW = 3072;

   typedef struct {
      int          due;
      logic        we;
      logic        err;
      logic [31:0] rdata;
      logic        trc;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   logic        rv [2];
   logic        rwe [2];
   logic [31:0] ra [2];
   logic [3:0]  rbe [2];
   logic [31:0] rwd [2];
   logic [31:0] rpc [2];
   logic        rrdy [2];
   logic        vv [2];
   logic [31:0] vrd [2];
   logic        verr [2];
   logic        tv [2];
   logic [31:0] tpc [2];
   logic [31:0] taddr [2];
   logic [31:0] tdata [2];

   int lat [2] = '{0, 3};
   logic [31:0] mdl [2][DW];
   exp_t eq [2][$];
   logic [31:0] last_rd [2];
   logic [31:0] last_td [2];
   int cyc = 0;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      dm_bus_responder #(
         .DEPTH_WORDS (DW),
         .LATENCY     (g == 0 ? 0 : 3),
         .ADDR_W      (32)
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (rv[g]),
         .req_ready  (rrdy[g]),
         .req_we     (rwe[g]),
         .req_addr   (ra[g]),
         .req_be     (rbe[g]),
         .req_wdata  (rwd[g]),
         .req_pc     (rpc[g]),
         .resp_valid (vv[g]),
         .resp_rdata (vrd[g]),
         .resp_err   (verr[g]),
         .trc_valid  (tv[g]),
         .trc_pc     (tpc[g]),
         .trc_addr   (taddr[g]),
         .trc_data   (tdata[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mrg(input logic [31:0] o,
                                       input logic [31:0] w,
                                       input logic [3:0] be);
      logic [31:0] m;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~m) | (w & m);
   endfunction

   // Reference: memory updated in acceptance order; every request
   // answers exactly 1+LATENCY cycles after it is accepted.
   always @(negedge clk) begin
      exp_t e;
      bit busy;
      int idx;
      logic [31:0] nw;
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            eq[d].delete();
            for (int w = 0; w < DW; w++) mdl[d][w] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            busy = 1'b0;
            for (int k = 0; k < eq[d].size(); k++)
               if (eq[d][k].due > cyc) busy = 1'b1;
            chk($sformatf("ready%0d", d), {31'b0, rrdy[d]}, {31'b0, !busy});
            if (vv[d]) begin
               if (eq[d].size() == 0) begin
                  chk($sformatf("spurious_resp%0d", d), {31'b0, vv[d]}, 0);
               end else begin
                  e = eq[d].pop_front();
                  chk($sformatf("resp_cycle%0d", d), cyc, e.due);
                  chk($sformatf("err%0d", d), {31'b0, verr[d]}, {31'b0, e.err});
                  if (e.err || !e.we) begin
                     chk($sformatf("rdata%0d", d), vrd[d], e.rdata);
                     if (!e.err) last_rd[d] = vrd[d];
                  end
                  chk($sformatf("trc_valid%0d", d), {31'b0, tv[d]}, {31'b0, e.trc});
                  if (e.trc) begin
                     chk($sformatf("trc_pc%0d", d), tpc[d], e.pc);
                     chk($sformatf("trc_addr%0d", d), taddr[d], e.addr);
                     chk($sformatf("trc_data%0d", d), tdata[d], e.data);
                     last_td[d] = tdata[d];
                  end
               end
            end else begin
               chk($sformatf("idle_trc%0d", d), {31'b0, tv[d]}, 0);
               chk($sformatf("idle_rdata%0d", d), vrd[d], 0);
               chk($sformatf("idle_err%0d", d), {31'b0, verr[d]}, 0);
               if (eq[d].size() != 0 && eq[d][0].due <= cyc) begin
                  chk($sformatf("missing_resp%0d", d), {31'b0, vv[d]}, 1);
                  void'(eq[d].pop_front());
               end
            end
            if (rv[d] && rrdy[d]) begin
               idx = int'(ra[d][31:2]);
               e.due = cyc + 1 + lat[d];
               e.we = rwe[d];
               e.err = (idx >= DW);
               e.rdata = '0;
               e.trc = 1'b0;
               e.pc = '0;
               e.addr = '0;
               e.data = '0;
               if (!e.err) begin
                  if (!rwe[d]) begin
                     e.rdata = mdl[d][idx];
                  end else if (rbe[d] != 4'b0000) begin
                     nw = mrg(mdl[d][idx], rwd[d], rbe[d]);
                     mdl[d][idx] = nw;
                     e.trc = 1'b1;
                     e.pc = rpc[d];
                     e.addr = idx * 4;
                     e.data = nw;
                  end
               end
               eq[d].push_back(e);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input int d, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] pc, output int acc);
      bit ok;
      int n;
      rv[d] = 1'b1;
      rwe[d] = we;
      ra[d] = a;
      rbe[d] = be;
      rwd[d] = wd;
      rpc[d] = pc;
      ok = 1'b0;
      n = 0;
      acc = -1;
      while (!ok && n < 40) begin
         @(negedge clk);
         ok = rrdy[d];
         if (ok) acc = cyc;
         @(posedge clk);
         #1;
         n++;
      end
      rv[d] = 1'b0;
      if (!ok) chk("accept_timeout", {31'b0, ok}, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((eq[0].size() != 0 || eq[1].size() != 0) && n < 40) begin
         idle(1);
         n++;
      end
      chk("drain", eq[0].size() + eq[1].size(), 0);
   endtask

   initial begin
      int a1, a2, idx;
      for (int d = 0; d < 2; d++) begin
         rv[d] = 1'b0;
         rwe[d] = 1'b0;
         ra[d] = '0;
         rbe[d] = '0;
         rwd[d] = '0;
         rpc[d] = '0;
         last_rd[d] = '1;
         last_td[d] = '1;
      end
      idle(2);
      reset = 1'b0;
      idle(2);

      issue(0, 1'b0, 32'h0, 4'hF, 32'h0, 32'h100, a1);
      drain();
      chk("reset_load", last_rd[0], 32'h0);

      issue(0, 1'b1, 32'h10, 4'b1111, 32'h12345678, 32'h3000, a1);
      issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h3004, a1);
      drain();
      chk("store_trc", last_td[0], 32'h12345678);
      chk("store_load", last_rd[0], 32'h12345678);

      issue(0, 1'b1, 32'h10, 4'b0100, 32'h00AB0000, 32'h3008, a1);
      issue(0, 1'b0, 32'h12, 4'b0000, 32'h0, 32'h300C, a1);
      drain();
      chk("fwd_trc", last_td[0], 32'h12AB5678);
      chk("fwd_load", last_rd[0], 32'h12AB5678);

      issue(0, 1'b1, 32'h0, 4'b1111, 32'hCAFEF00D, 32'h3010, a1);
      issue(0, 1'b1, 32'h3000, 4'b1111, 32'hDEADBEEF, 32'h3014, a1);
      issue(0, 1'b0, 32'h3000, 4'b0000, 32'h0, 32'h3018, a1);
      issue(0, 1'b1, 32'h4000, 4'b1111, 32'h0BADBAD0, 32'h301C, a1);
      issue(0, 1'b0, 32'h1, 4'b0000, 32'h0, 32'h3020, a1);
      drain();
      chk("oor_word0", last_rd[0], 32'hCAFEF00D);

      issue(1, 1'b1, 32'h20, 4'b1111, 32'hA5A5A5A5, 32'h4000, a1);
      issue(1, 1'b0, 32'h20, 4'b0000, 32'h0, 32'h4004, a2);
      chk("held_accept", a2, a1 + 4);
      drain();
      chk("lat3_load", last_rd[1], 32'hA5A5A5A5);

      issue(1, 1'b1, 32'h14, 4'b1111, 32'h11112222, 32'h4008, a1);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      issue(1, 1'b0, 32'h14, 4'b0000, 32'h0, 32'h400C, a1);
      issue(1, 1'b0, 32'h20, 4'b0000, 32'h0, 32'h4010, a1);
      issue(0, 1'b0, 32'h10, 4'b0000, 32'h0, 32'h4014, a1);
      drain();
      chk("post_reset_l3", last_rd[1], 32'h0);
      chk("post_reset_l0", last_rd[0], 32'h0);

      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
               0: idx = DW + int'($urandom_range(0, 1));
               1: idx = 4096 + int'($urandom_range(0, 1));
               default: idx = int'($urandom_range(0, 7));
            endcase
            issue(d, 1'($urandom_range(0, 1)),
                  {idx[29:0], 2'($urandom_range(0, 3))},
                  4'($urandom_range(0, 15)), $urandom, $urandom, a1);
            if ($urandom_range(0, 9) > 5) idle(int'($urandom_range(1, 2)));
         end
         drain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=%0d exp=done", cyc);
      $fatal(1, "watchdog");
   end

endmodule
